// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the tx frame scheduler: state encoding,
// generator interrupt codes and the payload length clamp.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    ABORT,
    IPG
  } sched_state_t;

  localparam logic [7:0] INT_NONE = 8'h00;
  localparam logic [7:0] INT_STOP = 8'h02;

  localparam int unsigned MIN_PAYLOAD = 46;
  localparam int unsigned MAX_PAYLOAD = 1500;

  function automatic int unsigned clamp_payload(input int unsigned len);
    if (len < MIN_PAYLOAD)      return MIN_PAYLOAD;
    else if (len > MAX_PAYLOAD) return MAX_PAYLOAD;
    else                        return len;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping, returned as a one-hot winner plus a valid flag.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((32'(ptr) + off) % NUM_REQ);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one frame generator between NUM_REQ requesters, one frame per grant,
// with abort handling and an enforced inter-packet gap.
// Optional watchdog on BUSY duration: define FRAME_SCHED_WATCHDOG_EN.
module tx_frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LEN_W       = 11,
  parameter int unsigned IPG_CYCLES  = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  input  logic                     i_abort,
  input  logic                     i_gen_done,
  output logic                     o_gen_start,
  output logic [LEN_W-1:0]         o_gen_len,
  output logic [7:0]               o_interrupt,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_aborted,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_frame_cnt,
  output logic                     o_wdog_err
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(IPG_CYCLES + 2);

  sched_state_t state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic               start_q, start_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [7:0]         int_q, int_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [NUM_REQ-1:0] done_q, done_n;
  logic               aborted_q, aborted_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [LEN_W-1:0]   win_len;
  logic               wd_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req  (i_req),
    .ptr  (ptr),
    .grant(arb_grant),
    .valid(arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) win_idx = PTR_W'(k);
    end
  end

  assign win_len = LEN_W'(clamp_payload(32'(i_req_len[32'(win_idx)*LEN_W +: LEN_W])));

`ifdef FRAME_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_err_q;

  assign wd_hit = (state == BUSY) && !i_gen_done && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (state == START)     wd_cnt <= '0;
      else if (state == BUSY) wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) wd_err_q <= 1'b1;
    end
  end

  assign o_wdog_err = wd_err_q;
`else
  // WDOG_CYCLES stays referenced so both builds share one parameter list.
  assign wd_hit     = (WDOG_CYCLES == 0) && 1'b0;
  assign o_wdog_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gap_cnt_n = gap_cnt;
    start_n   = 1'b0;
    len_n     = len_q;
    int_n     = int_q;
    grant_n   = grant_q;
    done_n    = '0;
    aborted_n = 1'b0;
    cnt_n     = cnt_q;
    case (state)
      IDLE: begin
        if (i_enable && arb_valid) begin
          state_n = START;
          start_n = 1'b1;
          grant_n = arb_grant;
          len_n   = win_len;
          ptr_n   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      START: state_n = BUSY;
      BUSY: begin
        // Done takes priority over a same-cycle abort or watchdog trip.
        if (i_gen_done) begin
          state_n   = IPG;
          done_n    = grant_q;
          cnt_n     = cnt_q + 1'b1;
          grant_n   = '0;
          gap_cnt_n = GAP_W'(IPG_CYCLES);
        end else if (i_abort || wd_hit) begin
          state_n = ABORT;
          int_n   = INT_STOP;
        end
      end
      ABORT: begin
        if (i_gen_done) begin
          state_n   = IPG;
          aborted_n = 1'b1;
          int_n     = INT_NONE;
          grant_n   = '0;
          gap_cnt_n = GAP_W'(IPG_CYCLES);
        end
      end
      IPG: begin
        if (gap_cnt <= GAP_W'(1)) state_n = IDLE;
        else                      gap_cnt_n = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gap_cnt   <= '0;
      start_q   <= 1'b0;
      len_q     <= '0;
      int_q     <= INT_NONE;
      grant_q   <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gap_cnt   <= gap_cnt_n;
      start_q   <= start_n;
      len_q     <= len_n;
      int_q     <= int_n;
      grant_q   <= grant_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
      cnt_q     <= cnt_n;
    end
  end

  assign o_gen_start = start_q;
  assign o_gen_len   = len_q;
  assign o_interrupt = int_q;
  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_aborted   = aborted_q;
  assign o_busy      = (state != IDLE);
  assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a frame-level reference model
// compared every cycle, plus hand-computed checks at key points.
module tb_tx_frame_scheduler;

  localparam int N   = 4;
  localparam int LW  = 11;
  localparam int IPG = 2;
  localparam int CW  = 16;
  localparam int WD  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, abort, gdone;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic            o_gen_start, o_aborted, o_busy, o_wdog_err;
  logic [LW-1:0]   o_gen_len;
  logic [7:0]      o_interrupt;
  logic [N-1:0]    o_grant, o_done;
  logic [CW-1:0]   o_frame_cnt;

  tx_frame_scheduler #(
    .NUM_REQ    (N),
    .LEN_W      (LW),
    .IPG_CYCLES (IPG),
    .CNT_W      (CW),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk        (clk),
    .i_rst      (rst),
    .i_enable   (en),
    .i_req      (req),
    .i_req_len  (req_len),
    .i_abort    (abort),
    .i_gen_done (gdone),
    .o_gen_start(o_gen_start),
    .o_gen_len  (o_gen_len),
    .o_interrupt(o_interrupt),
    .o_grant    (o_grant),
    .o_done     (o_done),
    .o_aborted  (o_aborted),
    .o_busy     (o_busy),
    .o_frame_cnt(o_frame_cnt),
    .o_wdog_err (o_wdog_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int clampv(input int v);
    if (v < 46)   return 46;
    if (v > 1500) return 1500;
    return v;
  endfunction

  // Frame-level reference: a frame is either in flight (aged from its start)
  // or the scheduler is serving a gap; otherwise it is free to grant.
  bit          m_valid, m_active, m_abort, trip;
  int          m_age, m_gap, m_ptr, m_win, m_bcnt;
  logic [N-1:0]  e_grant, e_done;
  logic          e_start, e_aborted, e_busy, e_werr;
  logic [LW-1:0] e_len;
  logic [7:0]    e_int;
  logic [CW-1:0] e_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_active = 0; m_abort = 0; m_age = 0; m_gap = 0;
      m_ptr = 0; m_win = 0; m_bcnt = 0;
      e_grant = '0; e_done = '0; e_start = 0; e_aborted = 0; e_busy = 0;
      e_werr = 0; e_len = '0; e_int = 8'h00; e_cnt = '0;
    end else if (m_valid) begin
      e_start = 0; e_done = '0; e_aborted = 0;
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_active) begin
        if (m_age == 0) begin
          m_age = 1; m_bcnt = 0;
        end else if (gdone) begin
          if (m_abort) begin e_aborted = 1; e_int = 8'h00; end
          else begin e_done = e_grant; e_cnt = e_cnt + 1'b1; end
          e_grant = '0; m_active = 0; m_abort = 0;
          m_gap = (IPG > 0) ? IPG : 1;
        end else if (!m_abort) begin
          trip = abort;
`ifdef FRAME_SCHED_WATCHDOG_EN
          m_bcnt++;
          if (m_bcnt == WD) begin trip = 1; e_werr = 1; end
`endif
          if (trip) begin m_abort = 1; e_int = 8'h02; end
        end
      end else if (en && req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin m_win = (m_ptr + k) % N; break; end
        end
        e_start = 1;
        e_grant = N'(1) << m_win;
        e_len   = LW'(clampv(int'(req_len[m_win*LW +: LW])));
        m_active = 1; m_age = 0;
        m_ptr = (m_win + 1) % N;
      end
      e_busy = m_active || (m_gap > 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid && !rst) begin
      chk("cmp_start",   32'(o_gen_start), 32'(e_start));
      chk("cmp_len",     32'(o_gen_len),   32'(e_len));
      chk("cmp_int",     32'(o_interrupt), 32'(e_int));
      chk("cmp_grant",   32'(o_grant),     32'(e_grant));
      chk("cmp_done",    32'(o_done),      32'(e_done));
      chk("cmp_aborted", 32'(o_aborted),   32'(e_aborted));
      chk("cmp_busy",    32'(o_busy),      32'(e_busy));
      chk("cmp_cnt",     32'(o_frame_cnt), 32'(e_cnt));
      chk("cmp_werr",    32'(o_wdog_err),  32'(e_werr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_gen_start) begin ok = 1; break; end
      tick();
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  // Called with the start pulse visible; done is sampled dly edges later.
  task automatic finish_frame(input int dly);
    repeat (dly - 1) tick();
    gdone = 1;
    tick();
    gdone = 0;
  endtask

  task automatic set_len(input int k, input int v);
    req_len[k*LW +: LW] = LW'(v);
  endtask

  logic [N-1:0] order [5];
  logic [N-1:0] exp_order [5];
  int done_cyc, n, starts;

  initial begin
    rst = 1; en = 0; abort = 0; gdone = 0; req = '0; req_len = '0;
    tick(); tick();
    rst = 0;
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_cnt",   32'(o_frame_cnt), 32'd0);
    chk("rst_grant", 32'(o_grant), 32'd0);

    // Single requester, basic frame
    req = 4'b0001; set_len(0, 100); en = 1;
    tick();
    chk("t1_start", 32'(o_gen_start), 32'd1);
    chk("t1_len",   32'(o_gen_len), 32'd100);
    chk("t1_grant", 32'(o_grant), 32'b0001);
    req = '0;
    tick();
    gdone = 1; tick(); gdone = 0;
    chk("t1_done",  32'(o_done), 32'b0001);
    chk("t1_cnt",   32'(o_frame_cnt), 32'd1);
    chk("t1_grant_clr", 32'(o_grant), 32'd0);

    // Round robin with all requesting, done 10 cycles after each start
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < N; k++) set_len(k, 60);
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start();
      order[f] = o_grant;
      if (f > 0) chk("rr_gap", 32'(cyc - done_cyc), 32'd3);
      finish_frame(10);
      done_cyc = cyc;
      chk("rr_done", 32'(o_done), 32'(order[f]));
    end
    req = '0;
    for (int f = 0; f < 5; f++) chk("rr_order", 32'(order[f]), 32'(exp_order[f]));
    chk("rr_cnt", 32'(o_frame_cnt), 32'd5);

    // Length clamping
    req = 4'b0001; set_len(0, 10);
    wait_start(); req = '0;
    chk("clamp_lo", 32'(o_gen_len), 32'd46);
    finish_frame(3);
    req = 4'b0010; set_len(1, 2000);
    wait_start(); req = '0;
    chk("clamp_hi", 32'(o_gen_len), 32'd1500);
    chk("clamp_hi_grant", 32'(o_grant), 32'b0010);
    finish_frame(3);

    // Abort in BUSY
    req = 4'b0100; set_len(2, 200);
    wait_start(); req = '0;
    tick();
    abort = 1; tick(); abort = 0;
    chk("ab_int", 32'(o_interrupt), 32'h02);
    chk("ab_grant_held", 32'(o_grant), 32'b0100);
    repeat (3) tick();
    chk("ab_int_held", 32'(o_interrupt), 32'h02);
    gdone = 1; tick(); gdone = 0;
    chk("ab_aborted", 32'(o_aborted), 32'd1);
    chk("ab_no_done", 32'(o_done), 32'd0);
    chk("ab_int_clr", 32'(o_interrupt), 32'h00);
    chk("ab_cnt",     32'(o_frame_cnt), 32'd7);

    // Abort and done together: done wins
    req = 4'b0100;
    wait_start(); req = '0;
    tick();
    abort = 1; gdone = 1; tick(); abort = 0; gdone = 0;
    chk("both_done",    32'(o_done), 32'b0100);
    chk("both_aborted", 32'(o_aborted), 32'd0);
    chk("both_cnt",     32'(o_frame_cnt), 32'd8);

    // Reset while aborting
    req = 4'b0010;
    wait_start(); req = '0;
    tick();
    abort = 1; tick(); abort = 0;
    chk("rm_int_pre", 32'(o_interrupt), 32'h02);
    rst = 1; tick(); rst = 0;
    chk("rm_int",   32'(o_interrupt), 32'h00);
    chk("rm_grant", 32'(o_grant), 32'd0);
    chk("rm_busy",  32'(o_busy), 32'd0);
    chk("rm_cnt",   32'(o_frame_cnt), 32'd0);
    req = 4'b1111;
    wait_start();
    chk("rm_next_grant", 32'(o_grant), 32'b0001);

    // Enable dropped mid-frame
    tick();
    en = 0;
    gdone = 1; tick(); gdone = 0;
    chk("en_done", 32'(o_done), 32'b0001);
    starts = 0;
    repeat (8) begin tick(); if (o_gen_start) starts++; end
    chk("en_no_start", 32'(starts), 32'd0);
    chk("en_idle", 32'(o_busy), 32'd0);
    en = 1;
    wait_start(); req = '0;
    chk("en_grant", 32'(o_grant), 32'b0010);
    finish_frame(4);
    repeat (4) tick();

`ifdef FRAME_SCHED_WATCHDOG_EN
    req = 4'b0001;
    wait_start(); req = '0;
    n = 0;
    while (o_interrupt != 8'h02 && n < 40) begin tick(); n++; end
    chk("wd_cycles", 32'(n), 32'd17);
    chk("wd_err", 32'(o_wdog_err), 32'd1);
    gdone = 1; tick(); gdone = 0;
    chk("wd_aborted", 32'(o_aborted), 32'd1);
    repeat (5) tick();
    chk("wd_sticky", 32'(o_wdog_err), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("wd_rst", 32'(o_wdog_err), 32'd0);
`else
    chk("wd_off", 32'(o_wdog_err), 32'd0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
